// File: rtl/lfsr_trigger_capture_if.sv
// Purpose : bundles the sample stream, arm/trigger controls and readout pop port of the capture stage.
// Latency : wiring only, no storage.
// Backpressure: none on the sample side; the reader paces readout with rd_en.
// Ports (master = generator/reader side, slave = capture stage):
//   sample_in/sample_valid, trig_level, arm, rd_en       master -> slave
//   rd_data/rd_valid, busy, done                         slave  -> master
interface lfsr_trigger_capture_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic [WIDTH-1:0] trig_level;
    logic             arm;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;

    modport master (
        output sample_in, sample_valid, trig_level, arm, rd_en,
        input  rd_data, rd_valid, busy, done
    );

    modport slave (
        input  sample_in, sample_valid, trig_level, arm, rd_en,
        output rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/lfsr_trigger_capture.sv
// Purpose : scope-style capture of a DEPTH-sample window around a rising level crossing, PRE samples before it.
// Latency : pop-to-data 1 cycle; READOUT starts 1 cycle after the (DEPTH-PRE-1)-th valid sample past the trigger.
// Backpressure: none upstream (samples outside a capture are dropped); readout advances only on rd_en.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   cap (slave)        sample_in/sample_valid, trig_level, arm, rd_en in; rd_data/rd_valid, busy, done out
module lfsr_trigger_capture #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 16,
    parameter int PRE    = 4,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    lfsr_trigger_capture_if.slave cap
);

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        READOUT
    } state_t;

    localparam int                POST_N   = DEPTH - PRE - 1;
    localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_A   = ADDR_W'(POST_N);
    localparam logic [ADDR_W-1:0] POP_LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W-1:0] rd_start;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] pop_cnt;
    logic [WIDTH-1:0]  level;
    logic [WIDTH-1:0]  prev;
    logic              prev_ok;

    logic capturing;
    logic wr;
    logic crossing;

    assign capturing = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
    assign wr        = capturing && cap.sample_valid;
    // prev_ok keeps the first sample after arm from looking like a crossing.
    assign crossing  = prev_ok && (prev < level) && (cap.sample_in >= level);

    // Buffer RAM is never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp] <= cap.sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wp          <= '0;
            rp          <= '0;
            rd_start    <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            pop_cnt     <= '0;
            level       <= '0;
            prev        <= '0;
            prev_ok     <= 1'b0;
            cap.rd_data <= '0;
            cap.rd_valid <= 1'b0;
            cap.busy    <= 1'b0;
            cap.done    <= 1'b0;
        end else begin
            cap.rd_valid <= 1'b0;

            // Write pointer wraps freely; the window is located via rd_start.
            if (wr) begin
                wp      <= wp + 1'b1;
                prev    <= cap.sample_in;
                prev_ok <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cap.arm) begin
                        state    <= PREFILL;
                        cap.busy <= 1'b1;
                        level    <= cap.trig_level;
                        pre_cnt  <= '0;
                        prev_ok  <= 1'b0;
                    end
                end

                PREFILL: begin
                    // Crossings are not evaluated here, so none can be remembered.
                    if (cap.sample_valid) begin
                        if (pre_cnt == PRE_LAST) begin
                            pre_cnt <= PRE_A;
                            state   <= WAIT_TRIG;
                        end else begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end
                    end
                end

                WAIT_TRIG: begin
                    if (cap.sample_valid && crossing) begin
                        // Trigger sample lands at wp, so the window opens PRE slots back.
                        rd_start <= wp - PRE_A;
                        post_cnt <= POST_A;
                        if (POST_N == 0) begin
                            state    <= READOUT;
                            cap.busy <= 1'b0;
                            cap.done <= 1'b1;
                            rp       <= wp - PRE_A;
                            pop_cnt  <= '0;
                        end else begin
                            state <= POST;
                        end
                    end
                end

                POST: begin
                    if (cap.sample_valid) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ADDR_W'(1)) begin
                            state    <= READOUT;
                            cap.busy <= 1'b0;
                            cap.done <= 1'b1;
                            rp       <= rd_start;
                            pop_cnt  <= '0;
                        end
                    end
                end

                READOUT: begin
                    if (cap.rd_en) begin
                        cap.rd_data  <= mem[rp];
                        cap.rd_valid <= 1'b1;
                        rp           <= rp + 1'b1;
                        pop_cnt      <= pop_cnt + 1'b1;
                        // done falls in the same cycle the final rd_valid appears.
                        if (pop_cnt == POP_LAST) begin
                            state    <= IDLE;
                            cap.done <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    cap.busy <= 1'b0;
                    cap.done <= 1'b0;
                end
            endcase
        end
    end

endmodule
